// File: rtl/sram_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// sram_lsu_ctrl : single-outstanding load/store front-end for a registered-input byte SRAM.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (reject misaligned half/word accesses).
// Revision: 1.0
// ============================================================================
module sram_lsu_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_csb_o,
  output logic                  mem_web_o,
  output logic [3:0]            mem_wmask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    err_q;
  logic                    mem_csb_q;
  logic                    mem_web_q;
  logic [3:0]              mem_wmask_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_din_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [2:0]              cnt_q;

  logic [3:0]              wmask_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic                    misalign_d;

  always_comb begin
    wmask_d = 4'b1111;
    case (req_size_i)
      2'd0:    wmask_d = 4'b0001;
      2'd1:    wmask_d = 4'b0011;
      default: wmask_d = 4'b1111;
    endcase
  end

  // Load data sits right-aligned in mem_dout because mem_addr is the exact byte address.
  always_comb begin
    rdata_d = mem_dout_i;
    case (size_q)
      2'd0:    rdata_d = {{24{~uns_q & mem_dout_i[7]}}, mem_dout_i[7:0]};
      2'd1:    rdata_d = {{16{~uns_q & mem_dout_i[15]}}, mem_dout_i[15:0]};
      default: rdata_d = mem_dout_i;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_d = (req_size_i == 2'd1) ? req_addr_i[0]
                    : ((req_size_i != 2'd0) && (|req_addr_i[1:0]));
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      mem_csb_q   <= 1'b0;
      mem_web_q   <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_csb_q   <= 1'b0;
      mem_web_q   <= 1'b0;
      mem_wmask_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            rsp_rdata_q <= '0;
            err_q       <= misalign_d;
            if (misalign_d) begin
              state_q <= S_RESP;
            end else begin
              // SRAM port is loaded here so the macro samples it on the ISSUE edge.
              state_q    <= S_ISSUE;
              mem_csb_q  <= 1'b1;
              mem_web_q  <= req_we_i;
              mem_addr_q <= req_addr_i;
              if (req_we_i) begin
                mem_wmask_q <= wmask_d;
                mem_din_q   <= req_wdata_i;
              end
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= 3'(READ_LAT - 1);
          state_q <= we_q ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            rsp_rdata_q <= rdata_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          // Stores and rejected requests arrive with rsp_valid low and raise it here.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_csb_o   = mem_csb_q;
  assign mem_web_o   = mem_web_q;
  assign mem_wmask_o = mem_wmask_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_din_o   = mem_din_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sram_lsu_ctrl : directed vector table plus randomized traffic against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_sram_lsu_ctrl;
  localparam int AW    = 13;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_csb, mem_web;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  int n_cmp = 0;
  int n_err = 0;

  sram_lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .mem_csb_o(mem_csb),
    .mem_web_o(mem_web), .mem_wmask_o(mem_wmask), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro model: read data is valid only in the cycle before the capture edge.
  logic [7:0]  sram [DEPTH];
  logic [31:0] dq [RL];
  assign mem_dout = dq[RL-1];

  always @(posedge clk) begin
    logic [31:0] rd;
    rd = $urandom;
    if (mem_csb) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_web) begin
          if (mem_wmask[k]) sram[(int'(mem_addr) + k) % DEPTH] <= mem_din[8*k +: 8];
        end else begin
          rd[8*k +: 8] = sram[(int'(mem_addr) + k) % DEPTH];
        end
      end
    end
    dq[0] <= rd;
    for (int i = 1; i < RL; i++) dq[i] <= dq[i-1];
  end

  // Reference memory and access semantics
  logic [7:0] ref_mem [DEPTH];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] s, input logic [AW-1:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return ((s == 2'd1) && a[0]) || ((s >= 2'd2) && (a[1:0] != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic ref_apply(input bit we, input logic [1:0] s, input bit u, input logic [AW-1:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int n;
    n   = nbytes(s);
    rd  = 32'h0;
    err = misaligned(s, a);
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (we) ref_mem[(int'(a) + k) % DEPTH] = wd[8*k +: 8];
        else    rd[8*k +: 8] = ref_mem[(int'(a) + k) % DEPTH];
      end
      if (!we && !u && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic scramble_req();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  // One complete transaction; entered and left at a negedge.
  task automatic run_req(input bit we, input logic [1:0] sz, input bit uns, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                         input logic [3:0] exp_wm, input int bp, input bit rel);
    bit mis, stray;
    int lat, exp_lat;
    mis     = misaligned(sz, a);
    exp_lat = mis ? 1 : (we ? 2 : 1 + RL);
    if (rel) rst_n = 1'b1;
    else     @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    scramble_req();
    check("req_ready_busy", req_ready, 0);
    check("rsp_valid_early", rsp_valid, 0);
    check("issue_csb", mem_csb, !mis);
    check("issue_web", mem_web, mis ? 1'b0 : we);
    if (!mis) begin
      check("issue_addr", mem_addr, a);
      check("issue_wmask", mem_wmask, we ? exp_wm : 4'h0);
      if (we) check("issue_din", mem_din, wd);
    end
    lat = 0; stray = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      scramble_req();
      if (mem_csb) stray = 1'b1;
    end
    check("rsp_latency", lat, exp_lat);
    check("no_extra_csb", stray, 0);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      scramble_req();
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, exp_rd);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_csb", mem_csb, 0);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          uns;
    logic [12:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [3:0]  wm;
    int          bp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rrd;
    bit          rerr;
    logic [1:0]  sz;
    logic [AW-1:0] a;
    bit          we, uns;
    logic [31:0] wd;

    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 4'hF, 0};
    tbl[1]  = '{1'b0, 2'd2, 1'b1, 13'h010, 32'h0,        32'hDEADBEEF,  1'b0, 4'h0, 5};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 13'h021, 32'h12345680, 32'h0000_0000, 1'b0, 4'h1, 0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 13'h021, 32'h0,        32'hFFFFFF80,  1'b0, 4'h0, 1};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 13'h021, 32'h0,        32'h00000080,  1'b0, 4'h0, 0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 13'h030, 32'h7777A55A, 32'h0000_0000, 1'b0, 4'h3, 2};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 13'h030, 32'h0,        32'hFFFFA55A,  1'b0, 4'h0, 0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 13'h030, 32'h0,        32'h0000A55A,  1'b0, 4'h0, 0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 13'h030, 32'h0,        32'h0000A55A,  1'b0, 4'h0, 0};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 13'h040, 32'h11223344, 32'h0000_0000, 1'b0, 4'hF, 0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 13'h040, 32'h0,        32'h11223344,  1'b0, 4'h0, 0};
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[11] = '{1'b0, 2'd2, 1'b0, 13'h013, 32'h0,        32'h0000_0000, 1'b1, 4'h0, 0};
`else
    tbl[11] = '{1'b0, 2'd2, 1'b0, 13'h013, 32'h0,        32'h000000DE,  1'b0, 4'h0, 0};
`endif

    // Reset held with a request pending
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 13'h155; req_wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_csb", mem_csb, 0);
    check("rst_web", mem_web, 0);
    check("rst_wmask", mem_wmask, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);

    ref_apply(1'b1, 2'd2, 1'b0, 13'h100, 32'hCAFEF00D, rrd, rerr);
    run_req(1'b1, 2'd2, 1'b0, 13'h100, 32'hCAFEF00D, 32'h0, 1'b0, 4'hF, 0, 1'b1);

    foreach (tbl[i]) begin
      ref_apply(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, rrd, rerr);
      run_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
              tbl[i].exp_rd, tbl[i].exp_err, tbl[i].wm, tbl[i].bp, 1'b0);
    end

    // Asynchronous reset in the middle of a load: no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 13'h010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", req_ready, 1);
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_csb", mem_csb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RL + 2) @(negedge clk);
    check("abandoned_no_rsp", rsp_valid, 0);
    check("abandoned_ready", req_ready, 1);

    // Randomized traffic against the reference memory
    for (int t = 0; t < 150; t++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      if ($urandom_range(0, 7) == 0) a = AW'(DEPTH - 4 + $urandom_range(0, 3));
      else                           a = AW'(13'h100 + $urandom_range(0, 31));
      ref_apply(we, sz, uns, a, wd, rrd, rerr);
      run_req(we, sz, uns, a, wd, rrd, rerr, we ? 4'((1 << nbytes(sz)) - 1) : 4'h0,
              $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
